// File: rtl/rra_req_frontend_if.sv
// Bus bundle between the rra request frontend and its environment: client write
// ports, arbiter req/gnt wires and the registered output port.
interface rra_req_frontend_if #(
  parameter int DATA_W = 8
);
  logic [3:0]          in_valid;
  logic [4*DATA_W-1:0] in_data;
  logic [3:0]          in_ready;
  logic                req0;
  logic                req1;
  logic                req2;
  logic                req3;
  logic                gnt0;
  logic                gnt1;
  logic                gnt2;
  logic                gnt3;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_id;
  logic                out_ready;
  logic                gnt_err;

  modport slave (
    input  in_valid, in_data, gnt0, gnt1, gnt2, gnt3, out_ready,
    output in_ready, req0, req1, req2, req3, out_valid, out_data, out_id, gnt_err
  );

  modport master (
    output in_valid, in_data, gnt0, gnt1, gnt2, gnt3, out_ready,
    input  in_ready, req0, req1, req2, req3, out_valid, out_data, out_id, gnt_err
  );
endinterface

// File: rtl/rra_req_frontend.sv
// Four per-client FIFOs feeding one registered output port; requests come from
// FIFO occupancy and the arbiter's one-hot grant selects which FIFO pops.
module rra_req_frontend #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  rra_req_frontend_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem    [4][DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr [4];
  logic [PTR_W-1:0]  r_rd_ptr [4];
  logic [CNT_W-1:0]  r_cnt    [4];

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [1:0]        r_out_id;
  logic              r_gnt_err;

  logic [3:0]        w_gnt;
  logic              w_gnt_multi;
  logic              w_gnt_onehot;
  logic              w_pop_ok;
  logic [3:0]        w_nempty;
  logic [3:0]        w_nfull;
  logic [3:0]        w_push;
  logic [3:0]        w_pop;
  logic              w_pop_any;
  logic [1:0]        w_pop_id;
  logic [DATA_W-1:0] w_pop_data;

  // Full/empty come from registered counts only, so a pop never frees a slot
  // for a push in the same cycle and a push never bypasses to the output.
  always_comb begin
    w_gnt        = {bus.gnt3, bus.gnt2, bus.gnt1, bus.gnt0};
    w_gnt_multi  = |(w_gnt & (w_gnt - 4'd1));
    w_gnt_onehot = (w_gnt != 4'd0) && !w_gnt_multi;
    w_pop_ok     = !r_out_valid || bus.out_ready;
    w_nempty     = '0;
    w_nfull      = '0;
    w_push       = '0;
    w_pop        = '0;
    w_pop_id     = '0;
    w_pop_data   = '0;
    for (int k = 0; k < 4; k++) begin
      w_nempty[k] = (r_cnt[k] != '0);
      w_nfull[k]  = (r_cnt[k] != CNT_W'(DEPTH));
      w_push[k]   = bus.in_valid[k] & w_nfull[k];
      w_pop[k]    = w_gnt[k] & w_gnt_onehot & w_nempty[k] & w_pop_ok;
      if (w_pop[k]) begin
        w_pop_id   = 2'(k);
        w_pop_data = r_mem[k][r_rd_ptr[k]];
      end
    end
    w_pop_any = |w_pop;
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (w_push[k]) begin
        r_mem[k][r_wr_ptr[k]] <= bus.in_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        r_wr_ptr[k] <= '0;
        r_rd_ptr[k] <= '0;
        r_cnt[k]    <= '0;
      end
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_gnt_err   <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_push[k]) begin
          r_wr_ptr[k] <= r_wr_ptr[k] + PTR_W'(1);
        end
        if (w_pop[k]) begin
          r_rd_ptr[k] <= r_rd_ptr[k] + PTR_W'(1);
        end
        r_cnt[k] <= r_cnt[k] + CNT_W'(w_push[k]) - CNT_W'(w_pop[k]);
      end
      if (w_pop_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_pop_data;
        r_out_id    <= w_pop_id;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_gnt_err <= w_gnt_multi;
    end
  end

  assign bus.in_ready  = w_nfull;
  assign bus.req0      = w_nempty[0];
  assign bus.req1      = w_nempty[1];
  assign bus.req2      = w_nempty[2];
  assign bus.req3      = w_nempty[3];
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_id    = r_out_id;
  assign bus.gnt_err   = r_gnt_err;
endmodule
